// File: rtl/spi_rx_slave.sv
`timescale 1ns/1ps
// spi_rx_slave
//   SPI mode-0 receiver (slave end). The three SPI lines are oversampled
//   in the clk domain. MSB-first words are shifted in, and each word is
//   presented on a valid/ready output port. Short frames and output
//   overruns are flagged with 1-cycle pulses.
//
//   Optional feature macro: SPI_RX_PARITY_EN
//     When defined, each word is followed by one even-parity bit. The
//     par_err output is added, and a word whose parity does not check is
//     discarded.
//
// Ports
//   clk        system clock
//   RSTn       async active-low reset (release synchronous to clk)
//   spi_cs     chip select, active low, asynchronous
//   spi_clk    SPI clock, idle low, sampled on rising edge, asynchronous
//   spi_data   serial data, MSB first
//   rx_data    received word, stable while rx_valid=1
//   rx_valid   word available
//   rx_ready   consumer accepts the word when rx_valid & rx_ready
//   frame_err  1-cycle pulse: CS deasserted mid-word
//   par_err    1-cycle pulse: parity mismatch (SPI_RX_PARITY_EN only)
//   overrun    1-cycle pulse: completed word dropped, output still full
//
// FSM states
//   state  | meaning
//   IDLE   | CS high (or not yet armed after reset); bit counter held at 0
//   SHIFT  | CS low; data bits shifted in on each rising spi_clk
//   PARITY | waiting for the parity bit after the last data bit (option)

module spi_rx_slave #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              spi_cs,
  input  logic              spi_clk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
`ifdef SPI_RX_PARITY_EN
  output logic              par_err,
`endif
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Without parity the last data bit goes straight to the output from the
  // synchroniser, so only DATA_W-1 bits need holding.
`ifdef SPI_RX_PARITY_EN
  localparam int SH_W = DATA_W;
`else
  localparam int SH_W = DATA_W - 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SPI_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   armed_q;
  logic                   clk_prev_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [SH_W-1:0]        shreg_q;
  logic [DATA_W-1:0]      rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   par_err_q;

  logic              cs_s;
  logic              clk_s;
  logic              data_s;
  logic              rise;
  logic              word_done;
  logic [DATA_W-1:0] word_val;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign rise   = clk_s & ~clk_prev_q;

  always_comb begin
    word_done = 1'b0;
`ifdef SPI_RX_PARITY_EN
    word_val  = shreg_q;
    word_done = (state_q == PARITY) && !cs_s && rise && (data_s == ^shreg_q);
`else
    word_val  = {shreg_q, data_s};
    word_done = (state_q == SHIFT) && !cs_s && rise && (bitcnt_q == LAST_BIT);
`endif
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      cs_sync_q   <= '1;
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      clk_prev_q  <= 1'b0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], spi_data};
      clk_prev_q  <= clk_s;

      // cs_s only reflects the real pin once the reset value has flushed
      // out of the chain; a CS already low at reset release must first be
      // seen high before a new frame may start.
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (fill_q[SYNC_STAGES-1] && cs_s)
        armed_q <= 1'b1;

      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_err_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          bitcnt_q <= '0;
          if (armed_q && !cs_s)
            state_q <= SHIFT;
        end
        SHIFT: begin
          // CS release wins over a coincident rising edge.
          if (cs_s) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            if (bitcnt_q != '0)
              frame_err_q <= 1'b1;
          end else if (rise) begin
            shreg_q <= {shreg_q[SH_W-2:0], data_s};
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_q <= '0;
`ifdef SPI_RX_PARITY_EN
              state_q  <= PARITY;
`endif
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
        end
`ifdef SPI_RX_PARITY_EN
        PARITY: begin
          if (cs_s) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end else if (rise) begin
            state_q <= SHIFT;
            if (data_s != ^shreg_q)
              par_err_q <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase

      if (word_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= word_val;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef SPI_RX_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_spi_rx_slave.sv
`timescale 1ns/1ps
module tb_spi_rx_slave;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        spi_cs;
  logic        spi_clk;
  logic        spi_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;
`ifdef SPI_RX_PARITY_EN
  logic        par_err;
`endif

  always #10 clk = ~clk;

  spi_rx_slave #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .spi_cs    (spi_cs),
    .spi_clk   (spi_clk),
    .spi_data  (spi_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef SPI_RX_PARITY_EN
    .par_err   (par_err),
`endif
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: records every handshake and counts error pulses.
  logic [15:0] got_q[$];
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int par_cnt = 0;

  always @(negedge clk) begin
    if (RSTn) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun)   ov_cnt = ov_cnt + 1;
`ifdef SPI_RX_PARITY_EN
      if (par_err)   par_cnt = par_cnt + 1;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_clk  = 1'b0;
      spi_data = v[i];
      repeat (5) tick();
      spi_clk  = 1'b1;
      repeat (5) tick();
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits({16'h0, w}, 16);
`ifdef SPI_RX_PARITY_EN
    send_bits({31'h0, ^w}, 1);
`endif
  endtask

  // Sends everything up to the final edge of a word, then raises spi_clk
  // for that final edge and returns right after driving it.
  task automatic send_word_to_last_edge(input logic [15:0] w);
    logic last;
`ifdef SPI_RX_PARITY_EN
    send_bits({16'h0, w}, 16);
    last = ^w;
`else
    send_bits({17'h0, w[15:1]}, 15);
    last = w[0];
`endif
    spi_clk  = 1'b0;
    spi_data = last;
    repeat (5) tick();
    spi_clk  = 1'b1;
  endtask

  task automatic start_frame();
    spi_clk = 1'b0;
    spi_cs  = 1'b0;
    repeat (5) tick();
  endtask

  task automatic end_frame();
    spi_clk = 1'b0;
    repeat (5) tick();
    spi_cs = 1'b1;
    repeat (6) tick();
  endtask

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          exp_fe;
    int          exp_words;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  int          got_base, fe_base, ov_base, par_base, exp_fe;

  initial begin
    RSTn     = 1'b0;
    spi_cs   = 1'b1;
    spi_clk  = 1'b0;
    spi_data = 1'b0;
    rx_ready = 1'b1;

    // ---- reset state
    tick();
    check("reset_rx_data",   {16'h0, rx_data}, 32'h0);
    check("reset_rx_valid",  {31'h0, rx_valid}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_overrun",   {31'h0, overrun}, 32'h0);
`ifdef SPI_RX_PARITY_EN
    check("reset_par_err",   {31'h0, par_err}, 32'h0);
`endif
    RSTn = 1'b1;
    repeat (6) tick();

    // ---- basic word with latency check
    got_base = got_q.size(); fe_base = fe_cnt;
    start_frame();
    send_word_to_last_edge(16'hA55A);
    tick();
    check("lat_edge_plus1", {31'h0, rx_valid}, 32'h0);
    tick();
    check("lat_edge_plus2", {31'h0, rx_valid}, 32'h0);
    tick();
    check("lat_edge_plus3", {31'h0, rx_valid}, 32'h1);
    check("basic_data", {16'h0, rx_data}, 32'hA55A);
    repeat (3) tick();
    end_frame();
    check("basic_count", got_q.size() - got_base, 1);
    check("basic_fe", fe_cnt - fe_base, 0);

    // ---- back-to-back words in one CS assertion
    got_base = got_q.size(); fe_base = fe_cnt;
    start_frame();
    send_word(16'h1234);
    send_word(16'hFFFF);
    end_frame();
    check("b2b_count", got_q.size() - got_base, 2);
    if (got_q.size() - got_base == 2) begin
      check("b2b_word0", {16'h0, got_q[got_base]}, 32'h1234);
      check("b2b_word1", {16'h0, got_q[got_base+1]}, 32'hFFFF);
    end
    check("b2b_fe", fe_cnt - fe_base, 0);

    // ---- table-driven frames (full words and short frames)
    vecs[0] = '{16'h1234, 9,  1, 0};
    vecs[1] = '{16'h00FF, 16, 0, 1};
    vecs[2] = '{16'h0000, 16, 0, 1};
    vecs[3] = '{16'h8001, 1,  1, 0};
    vecs[4] = '{16'h7FFE, 15, 1, 0};
    vecs[5] = '{16'hC35A, 16, 0, 1};
    vecs[6] = '{16'h0000, 0,  0, 0};
    vecs[7] = '{16'h8000, 16, 0, 1};
    for (int v = 0; v < 8; v++) begin
      got_base = got_q.size(); fe_base = fe_cnt;
      start_frame();
      if (vecs[v].nbits == 16)
        send_word(vecs[v].word);
      else if (vecs[v].nbits > 0)
        send_bits({16'h0, vecs[v].word >> (16 - vecs[v].nbits)}, vecs[v].nbits);
      end_frame();
      check($sformatf("vec%0d_count", v), got_q.size() - got_base, vecs[v].exp_words);
      if (vecs[v].exp_words == 1 && got_q.size() - got_base == 1)
        check($sformatf("vec%0d_data", v), {16'h0, got_q[got_base]}, {16'h0, vecs[v].word});
      check($sformatf("vec%0d_fe", v), fe_cnt - fe_base, vecs[v].exp_fe);
      check($sformatf("vec%0d_valid", v), {31'h0, rx_valid}, 32'h0);
    end

    // ---- overrun
    rx_ready = 1'b0;
    got_base = got_q.size(); ov_base = ov_cnt;
    start_frame();
    send_word(16'h0001);
    send_word(16'h0002);
    end_frame();
    check("ovr_pulses", ov_cnt - ov_base, 1);
    check("ovr_valid_held", {31'h0, rx_valid}, 32'h1);
    check("ovr_data_held", {16'h0, rx_data}, 32'h0001);
    check("ovr_no_hs", got_q.size() - got_base, 0);
    rx_ready = 1'b1;
    repeat (3) tick();
    check("ovr_drain_valid", {31'h0, rx_valid}, 32'h0);
    check("ovr_drain_count", got_q.size() - got_base, 1);
    if (got_q.size() - got_base == 1)
      check("ovr_drain_data", {16'h0, got_q[got_base]}, 32'h0001);

    // ---- same-cycle accept while word 2 completes
    rx_ready = 1'b0;
    got_base = got_q.size(); ov_base = ov_cnt;
    start_frame();
    send_word(16'h5A01);
    send_word_to_last_edge(16'hC3C3);
    tick();
    tick();
    rx_ready = 1'b1;
    tick();
    check("same_valid", {31'h0, rx_valid}, 32'h1);
    check("same_data", {16'h0, rx_data}, 32'hC3C3);
    repeat (3) tick();
    end_frame();
    check("same_ovr", ov_cnt - ov_base, 0);
    check("same_count", got_q.size() - got_base, 2);
    if (got_q.size() - got_base == 2) begin
      check("same_word0", {16'h0, got_q[got_base]}, 32'h5A01);
      check("same_word1", {16'h0, got_q[got_base+1]}, 32'hC3C3);
    end

    // ---- reset mid-frame
    got_base = got_q.size(); fe_base = fe_cnt;
    start_frame();
    send_bits(32'h5D, 7);
    RSTn = 1'b0;
    #1;
    check("rst_mid_data",  {16'h0, rx_data}, 32'h0);
    check("rst_mid_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_mid_fe",    {31'h0, frame_err}, 32'h0);
    check("rst_mid_ovr",   {31'h0, overrun}, 32'h0);
    repeat (2) tick();
    RSTn = 1'b1;
    send_bits(32'h1A5, 9);
`ifdef SPI_RX_PARITY_EN
    send_bits(32'h1, 1);
`endif
    end_frame();
    check("rst_tail_count", got_q.size() - got_base, 0);
    check("rst_tail_fe", fe_cnt - fe_base, 0);
    start_frame();
    send_word(16'hBEEF);
    end_frame();
    check("rst_next_count", got_q.size() - got_base, 1);
    if (got_q.size() - got_base == 1)
      check("rst_next_data", {16'h0, got_q[got_base]}, 32'hBEEF);

`ifdef SPI_RX_PARITY_EN
    // ---- parity
    got_base = got_q.size(); par_base = par_cnt;
    start_frame();
    send_bits(32'h3, 16);
    send_bits(32'h0, 1);
    end_frame();
    check("par_good_count", got_q.size() - got_base, 1);
    check("par_good_err", par_cnt - par_base, 0);
    got_base = got_q.size(); par_base = par_cnt;
    start_frame();
    send_bits(32'h3, 16);
    send_bits(32'h1, 1);
    end_frame();
    check("par_bad_count", got_q.size() - got_base, 0);
    check("par_bad_err", par_cnt - par_base, 1);
`endif

    // ---- randomized frames against a word-queue model
    got_base = got_q.size(); fe_base = fe_cnt; ov_base = ov_cnt;
    exp_fe = 0;
    exp_q.delete();
    for (int f = 0; f < 12; f++) begin
      int nw, tail;
      logic [15:0] w;
      nw   = $urandom_range(1, 3);
      tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      start_frame();
      for (int k = 0; k < nw; k++) begin
        w = 16'($urandom);
        exp_q.push_back(w);
        send_word(w);
      end
      if (tail != 0) begin
        send_bits($urandom, tail);
        exp_fe++;
      end
      end_frame();
    end
    check("rand_count", got_q.size() - got_base, exp_q.size());
    if (got_q.size() - got_base == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("rand_word%0d", i), {16'h0, got_q[got_base+i]}, {16'h0, exp_q[i]});
    end
    check("rand_fe", fe_cnt - fe_base, exp_fe);
    check("rand_ovr", ov_cnt - ov_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_rx_slave.md
Name: spi_rx_slave

Overview:
- SPI receiver (slave end) for the link driven by the top-level SPI transmitter outputs spi_cs/spi_clk/spi_data.
- Oversamples the three SPI lines in the clk domain, shifts in MSB-first words and presents each word on a valid/ready output port.
- Flags short frames and output overrun. Used as loopback checker and as the receive side on the far board.

Parameters:
- DATA_W, 16, bits per word; legal range 4..32.
- SYNC_STAGES, 2, flip-flop stages on each SPI input; legal range 2..3.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- RSTn  input  1  asynchronous active-low reset; release is synchronous to clk.
- spi_cs  input  1  chip select, active low, asynchronous to clk.
- spi_clk  input  1  SPI clock, mode 0 (idle low, sample on rising edge), asynchronous to clk.
- spi_data  input  1  serial data, MSB first.
- rx_data  output  DATA_W  received word; stable while rx_valid=1.
- rx_valid  output  1  word available.
- rx_ready  input  1  consumer accepts the word when rx_valid=1 and rx_ready=1 on a clk edge.
- frame_err  output  1  1-cycle pulse: CS deasserted mid-word.
- overrun  output  1  1-cycle pulse: completed word dropped because the output was still full.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0. Reset also clears the synchronisers (cs_s=1, clk_s=0), the bit counter and the FSM (state IDLE).
- Input sync: each input passes through SYNC_STAGES flops. The rising edge of spi_clk is detected as clk_s=1 with the previous clk_s=0.
- Timing requirement: spi_clk high time and low time are each at least 3 clk periods. spi_data must be stable for at least 2 clk periods around the rising edge. Violations are outside the spec.
- State IDLE:
  - cs_s=1; the bit counter is held at 0.
  - cs_s falling moves to SHIFT.
- State SHIFT:
  - On each detected rising edge: shreg <= {shreg[DATA_W-2:0], data_s}; bitcnt increments.
  - When bitcnt reaches DATA_W-1 and an edge arrives, the word is complete and bitcnt wraps to 0.
  - If cs_s is still 0 after a complete word, the FSM stays in SHIFT; back-to-back words within one CS assertion are allowed.
  - cs_s rising with bitcnt=0 returns to IDLE with no error.
  - cs_s rising with bitcnt!=0 returns to IDLE, discards the partial word and pulses frame_err for 1 cycle.
  - A rising edge and cs_s rising in the same cycle: the edge is ignored and cs is processed.
- Output latency: rx_valid rises on the clk edge after the cycle in which the last-bit rising edge is detected.
- Output register:
  - rx_valid clears on a handshake (rx_valid=1 and rx_ready=1) with no new word completing.
  - Complete word with rx_valid=0: load rx_data, set rx_valid.
  - Complete word with rx_valid=1 and rx_ready=1 in the same cycle: load the new word; rx_valid stays 1.
  - Complete word with rx_valid=1 and rx_ready=0: the new word is dropped; rx_data and rx_valid are unchanged; overrun pulses for 1 cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the FSM waits in IDLE for a fresh falling edge of cs_s; a CS already low at release is ignored until it goes high and then low again.
- CS low while spi_clk is high is not a legal entry; the first edge counted is the first rising edge after CS falls.

Optional Feature:
- Macro: SPI_RX_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit (DATA_W+1 edges per word); FSM state PARITY follows the last data bit.
  - Output port par_err (1 bit, reset 0) is added. On a parity mismatch the word is discarded and par_err pulses for 1 cycle.
  - A cs_s rise while in PARITY counts as a frame error.
- Undefined: no parity bit, no par_err port, and the FSM has only IDLE/SHIFT.

Test Plan:
- Basic word: RSTn low for 20 ns, CS low, send 0xA55A at spi_clk period 200 ns, CS high, rx_ready=1 -> a single rx_valid pulse with rx_data=0xA55A, arriving 1 clk after the synced 16th edge; no errors.
- Back-to-back words: send 0x1234 then 0xFFFF within one CS low, rx_ready=1 -> two handshakes, 0x1234 then 0xFFFF; frame_err=0.
- Short frame: CS low, 9 bits, CS high -> frame_err pulses once, rx_valid stays 0; the next frame 0x00FF is received correctly.
- Overrun: rx_ready=0, send 0x0001 then 0x0002 -> rx_data=0x0001 held, overrun pulses once. Raising rx_ready then gives one handshake, and rx_valid drops.
- Same-cycle accept: raise rx_ready in the exact cycle word 2 completes -> rx_valid stays 1, rx_data=word 2, no overrun.
- Reset mid-frame: RSTn low after 7 bits with CS still low -> all outputs are 0. After release, the rest of the bits are ignored until CS toggles; the next frame 0xBEEF is received.
- With SPI_RX_PARITY_EN: send 0x0003 with parity 0 -> received. Send 0x0003 with parity 1 -> par_err pulse and no rx_valid.
